// File: rtl/argmax_chunk_scheduler.sv
// Chunked argmax job sequencer: folds per-chunk (max, lane) results into one global (max, argmax).
// Optional macro ARGMAX_CHUNK_SCHEDULER_TIE_LAST_EN makes ties resolve to the latest index.
module argmax_chunk_scheduler #(
   parameter int WIDTH        = 8,
   parameter int ARGMAX_WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic        [ARGMAX_WIDTH-5:0] num_chunks,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic signed [WIDTH-1:0]        in_max,
   input  logic        [3:0]              in_argmax,
   output logic                           busy,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic signed [WIDTH-1:0]        max,
   output logic        [ARGMAX_WIDTH-1:0] argmax
);

   localparam int CW = ARGMAX_WIDTH - 4;

   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

   state_t          state;
   logic [CW-1:0]   chunk_cnt;
   logic [CW-1:0]   last_idx;

   function automatic logic replace(input logic signed [WIDTH-1:0] cand,
                                    input logic signed [WIDTH-1:0] best);
`ifdef ARGMAX_CHUNK_SCHEDULER_TIE_LAST_EN
      return cand >= best;
`else
      return cand > best;
`endif
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         max       <= '0;
         argmax    <= '0;
         chunk_cnt <= '0;
         last_idx  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  // num_chunks=0 wraps to all-ones, i.e. 2^CW chunks
                  last_idx  <= num_chunks - CW'(1);
                  chunk_cnt <= '0;
                  state     <= COLLECT;
                  in_ready  <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            COLLECT: begin
               if (in_valid && in_ready) begin
                  if (chunk_cnt == '0 || replace(in_max, max)) begin
                     max    <= in_max;
                     argmax <= {chunk_cnt, in_argmax};
                  end
                  chunk_cnt <= chunk_cnt + CW'(1);
                  if (chunk_cnt == last_idx) begin
                     state     <= DONE;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_argmax_chunk_scheduler.sv
// Scoreboard bench for argmax_chunk_scheduler: directed plan cases plus randomized jobs.
module tb_argmax_chunk_scheduler;

   localparam int WIDTH        = 8;
   localparam int ARGMAX_WIDTH = 8;

   logic                           clk = 1'b0;
   logic                           rst;
   logic                           start;
   logic        [ARGMAX_WIDTH-5:0] num_chunks;
   logic                           in_valid;
   logic                           in_ready;
   logic signed [WIDTH-1:0]        in_max;
   logic        [3:0]              in_argmax;
   logic                           busy;
   logic                           out_valid;
   logic                           out_ready;
   logic signed [WIDTH-1:0]        max;
   logic        [ARGMAX_WIDTH-1:0] argmax;

   argmax_chunk_scheduler #(.WIDTH(WIDTH), .ARGMAX_WIDTH(ARGMAX_WIDTH)) dut (
      .clk(clk), .rst(rst), .start(start), .num_chunks(num_chunks),
      .in_valid(in_valid), .in_ready(in_ready), .in_max(in_max), .in_argmax(in_argmax),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .max(max), .argmax(argmax)
   );

   always #5 clk = ~clk;

   typedef struct {int m; int a;} exp_t;
   exp_t exp_q[$];
   int   cm[$];
   int   ci[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   // Monitor: a result is consumed on the edge after out_valid && out_ready is seen.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("result_max", longint'(max), e.m);
            check("result_argmax", longint'(argmax), e.a);
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy) check("idle_timeout", 1, 0);
   endtask

   // Reference: scan chunks in order, global index = chunk*16 + lane.
   function automatic exp_t model(input int len);
      exp_t e;
      e.m = cm[0];
      e.a = ci[0];
      for (int k = 1; k < len; k++) begin
`ifdef ARGMAX_CHUNK_SCHEDULER_TIE_LAST_EN
         if (cm[k] >= e.m) begin
`else
         if (cm[k] > e.m) begin
`endif
            e.m = cm[k];
            e.a = k * 16 + ci[k];
         end
      end
      return e;
   endfunction

   task automatic run_job(input int ncode, input int gap, input int hold);
      int   len;
      exp_t e;
      len = (ncode == 0) ? 16 : ncode;
      wait_idle();
      e = model(len);
      exp_q.push_back(e);
      start = 1'b1;
      num_chunks = 4'(ncode);
      @(posedge clk); #1;
      start = 1'b0;
      out_ready = (hold == 0);
      for (int k = 0; k < len; k++) begin
         in_valid  = 1'b1;
         in_max    = WIDTH'(cm[k]);
         in_argmax = 4'(ci[k]);
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (k < len - 1) begin
            for (int g = 0; g < gap; g++) begin
               check("in_ready_gap", in_ready, 1);
               @(posedge clk); #1;
            end
         end
      end
      check("out_valid_latency", out_valid, 1);
      check("in_ready_done", in_ready, 0);
      for (int h = 0; h < hold; h++) begin
         start = ~start;
         check("held_valid", out_valid, 1);
         check("held_max", longint'(max), e.m);
         check("held_argmax", longint'(argmax), e.a);
         @(posedge clk); #1;
      end
      start = (hold > 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("idle_busy", busy, 0);
      check("idle_out_valid", out_valid, 0);
   endtask

   task automatic set_chunks(input int m0, input int i0, input int m1, input int i1,
                             input int m2, input int i2, input int n);
      cm.delete(); ci.delete();
      cm.push_back(m0); ci.push_back(i0);
      if (n > 1) begin cm.push_back(m1); ci.push_back(i1); end
      if (n > 2) begin cm.push_back(m2); ci.push_back(i2); end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; num_chunks = '0; in_valid = 1'b0;
      in_max = '0; in_argmax = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_max", longint'(max), 0);
      check("rst_argmax", longint'(argmax), 0);
      rst = 1'b0;

      // in_valid in IDLE must not be consumed
      in_valid = 1'b1; in_max = 8'sd50;
      @(posedge clk); #1;
      check("idle_no_accept_ready", in_ready, 0);
      check("idle_no_accept_max", longint'(max), 0);
      in_valid = 1'b0;

      set_chunks(5, 2, 9, 7, 4, 0, 3);
      run_job(3, 0, 0);
      set_chunks(-128, 0, -1, 15, 0, 0, 2);
      run_job(2, 2, 0);
      set_chunks(7, 3, 7, 1, 0, 0, 2);
      run_job(2, 0, 0);
      cm.delete(); ci.delete();
      for (int k = 0; k < 16; k++) begin cm.push_back(k - 8); ci.push_back(k % 16); end
      run_job(0, 0, 0);
      set_chunks(-5, 9, -7, 2, -128, 6, 3);
      run_job(3, 0, 5);
      // new start accepted the cycle after returning to IDLE
      set_chunks(-128, 11, 0, 0, 0, 0, 1);
      run_job(1, 0, 0);

      // abort after 2 of 3 beats
      wait_idle();
      start = 1'b1; num_chunks = 4'd3;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1; in_max = 8'sd20; in_argmax = 4'(k);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_in_ready", in_ready, 0);
      check("abort_out_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_max", longint'(max), 0);
      check("abort_argmax", longint'(argmax), 0);
      set_chunks(3, 4, 0, 0, 0, 0, 1);
      run_job(1, 0, 0);

      for (int j = 0; j < 20; j++) begin
         int ncode, len;
         ncode = $urandom_range(0, 15);
         len = (ncode == 0) ? 16 : ncode;
         cm.delete(); ci.delete();
         for (int k = 0; k < len; k++) begin
            if (j % 2 == 0) cm.push_back($urandom_range(0, 3) - 2);
            else            cm.push_back($urandom_range(0, 255) - 128);
            ci.push_back($urandom_range(0, 15));
         end
         run_job(ncode, $urandom_range(0, 2), $urandom_range(0, 3));
      end

      repeat (3) @(posedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/argmax_chunk_scheduler.md
Name: argmax_chunk_scheduler

Overview:
Sequences a multi-chunk signed argmax job over a 16-lane parallel argmax stage. Each chunk arrives as one 16-lane (max, local index) result from the combinational parallel argmax stage. The block counts chunks and keeps the running global max and index. It returns one final (max, argmax) per job through a ready/valid result port. It sits between the feature-vector streamer upstream and the classifier output register downstream.

Parameters:
WIDTH, 8, signed data width of chunk max and result max
ARGMAX_WIDTH, 8, width of the global index; the maximum number of chunks is 2^(ARGMAX_WIDTH-4)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new job; sampled only in IDLE
num_chunks  input  ARGMAX_WIDTH-4  chunks in the job; 0 encodes 2^(ARGMAX_WIDTH-4); sampled with start
in_valid  input  1  chunk result valid
in_ready  output  1  scheduler accepts a chunk
in_max  input  WIDTH  signed max of the current 16-lane chunk
in_argmax  input  4  lane index of in_max within the chunk
busy  output  1  high in COLLECT and DONE
out_valid  output  1  final result valid
out_ready  input  1  consumer accepts the result
max  output  WIDTH  signed global max
argmax  output  ARGMAX_WIDTH  global index of max

Behaviour:
- Reset (synchronous, active-high, checked each clk edge): state=IDLE; in_ready=0, out_valid=0, busy=0, max=0, argmax=0; chunk counter=0; latched length=0. Reset has priority over every other event and aborts any job in progress. No partial result is produced after an abort.
- FSM states: IDLE, COLLECT, DONE. All outputs are registered.
- IDLE:
  - in_ready=0.
  - When start=1: latch num_chunks as length L (0 maps to 2^(ARGMAX_WIDTH-4)), clear the chunk counter, go to COLLECT.
  - start is ignored in COLLECT and DONE.
- COLLECT:
  - in_ready=1 and busy=1.
  - A beat transfers when in_valid && in_ready.
  - Candidate index = {chunk_cnt, in_argmax}, i.e. chunk_cnt*16 + in_argmax.
  - First beat (chunk_cnt=0): load max=in_max and argmax=candidate unconditionally.
  - Later beats: replace only if $signed(in_max) > $signed(max) (strict). Ties therefore keep the earliest index.
  - chunk_cnt increments on each beat.
  - On the beat with chunk_cnt==L-1: go to DONE, drop in_ready in the next cycle, and assert out_valid in the next cycle. Latency from the last accepted beat to out_valid is 1 cycle.
  - Idle cycles (in_valid=0) hold all state.
- DONE:
  - out_valid=1 and busy=1; max and argmax are stable.
  - When out_ready=1: go to IDLE next cycle and clear out_valid. max and argmax keep their values until the next job's first beat.
  - start arriving in the same cycle as the handshake is ignored; the earliest new job starts from IDLE one cycle later.
- Throughput: 1 chunk per cycle. A job takes L+2 cycles minimum (start, L beats, result).
- Widths:
  - Signed comparison at WIDTH.
  - The counter is ARGMAX_WIDTH-4 bits. With L = 2^(ARGMAX_WIDTH-4) the terminal count is all-ones, so there is no overflow.
  - Chunk indices are never truncated.
- Boundaries:
  - L=1: DONE follows the single beat.
  - Most negative in_max values are handled correctly.
  - in_valid asserted in IDLE or DONE is not consumed (in_ready=0).

Optional Feature:
ARGMAX_CHUNK_SCHEDULER_TIE_LAST_EN
- Defined: the comparison becomes >=, so on ties the latest index wins.
- Undefined: strict >, so the earliest index wins.
- Affects only the replace condition. Interface and timing are unchanged.

Test Plan:
- WIDTH=8, ARGMAX_WIDTH=8, start with num_chunks=3; chunks (max,idx) = (5,2),(9,7),(4,0) back-to-back -> out_valid 1 cycle after beat 3; max=9, argmax=23.
- num_chunks=2; chunks (-128,0),(-1,15) with 2-cycle in_valid gaps -> max=-1, argmax=31; in_ready stays 1 through the gaps.
- Tie case, num_chunks=2; chunks (7,3),(7,1) -> argmax=3 by default; argmax=17 with ARGMAX_CHUNK_SCHEDULER_TIE_LAST_EN.
- num_chunks=0 (16 chunks); chunk k carries (k-8, k mod 16) -> max=7, argmax=255; the counter does not overflow.
- Back-pressure: hold out_ready=0 for 5 cycles with start pulsing -> out_valid, max and argmax are held, start is ignored; out_ready=1 -> IDLE; a new start is accepted the next cycle.
- Assert rst after 2 of 3 beats -> next cycle: IDLE with all outputs 0. A new job with num_chunks=1 and chunk (3,4) -> max=3, argmax=4.
